rot_shift_seq: RTL and testbench

- Parametrised, sequential successor to the team's fixed 4-bit rotator.
- Rotates or shifts a WIDTH-bit word left or right by a run-time amount, one bit position per clock, under an iterative FSM.
- Valid/ready handshakes on both sides.
- Used where area matters more than latency, e.g. serial bit-alignment and simple crypto/CRC datapaths.

---
 rtl/rot_shift_seq.sv | 190 +++++++++++++++++++
 tb/tb_rot_shift_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_shift_seq.sv
// rot_shift_seq -- iterative rotate / shift unit, one bit position per clock.
//
// The request is loaded on the accept edge, stepped once per clock in BUSY
// while the remaining count drains, and then presented in DONE until the
// consumer takes it. Zero-amount requests skip BUSY and go straight to DONE.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds in_valid and its payload until it sees
// in_ready. This block holds out_valid and out_data (and the flags) stable
// until out_ready. in_ready is combinational from state, out_ready and rst,
// so a new request can be taken on the same edge the result is consumed.
//
// Optional build macro: ROT_SHIFT_SEQ_FLAGS_EN adds the out_zero and
// out_last result flags. Without it those ports and registers are absent.
//
// o_dbg_state exposes the FSM state (0 IDLE, 1 BUSY, 2 DONE) for observation.

module rot_shift_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
`ifdef ROT_SHIFT_SEQ_FLAGS_EN
    output logic             out_zero,
    output logic             out_last,
`endif
    output logic [1:0]       o_dbg_state
);

    // Operation encodings; 2'b11 falls through to rotate.
    localparam logic [1:0] MODE_ROT = 2'b00;
    localparam logic [1:0] MODE_LSH = 2'b01;
    localparam logic [1:0] MODE_ASH = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_count;
    logic             r_dir;
    logic [1:0]       r_mode;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_consume;
    logic             w_count_last;
    logic [WIDTH-1:0] w_step_data;
    logic             w_step_bit;

    // Handshake terms shared by the FSM and the datapath.
    always_comb begin
        w_in_ready   = 1'b0;
        if (!rst) begin
            w_in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
        end
        w_accept     = in_valid && w_in_ready;
        w_consume    = (r_state == DONE) && out_ready;
        w_count_last = (r_count == AMT_W'(1));
    end

    // One-position step of the current word, plus the bit that leaves the edge.
    always_comb begin
        w_step_data = r_data;
        w_step_bit  = 1'b0;
        if (r_dir) begin
            // Left: the MSB leaves the word.
            w_step_bit = r_data[WIDTH-1];
            case (r_mode)
                MODE_LSH,
                MODE_ASH: w_step_data = {r_data[WIDTH-2:0], 1'b0};
                default:  w_step_data = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            endcase
        end else begin
            // Right: the LSB leaves the word.
            w_step_bit = r_data[0];
            case (r_mode)
                MODE_LSH: w_step_data = {1'b0, r_data[WIDTH-1:1]};
                MODE_ASH: w_step_data = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
                default:  w_step_data = {r_data[0], r_data[WIDTH-1:1]};
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: accept, count down, present, release or reload.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (in_amt != '0) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (w_count_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_accept) begin
                    w_state_nxt = (in_amt != '0) ? BUSY : DONE;
                end else if (w_consume) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, step while BUSY, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_mode  <= MODE_ROT;
        end else if (w_accept) begin
            r_data  <= in_data;
            r_count <= in_amt;
            r_dir   <= in_dir;
            r_mode  <= in_mode;
        end else if (r_state == BUSY) begin
            r_data  <= w_step_data;
            r_count <= r_count - AMT_W'(1);
        end
    end

`ifdef ROT_SHIFT_SEQ_FLAGS_EN
    logic r_last;

    // Edge bit of the most recent step; zero on accept so amt=0 reports 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if (w_accept) begin
            r_last <= 1'b0;
        end else if (r_state == BUSY) begin
            r_last <= w_step_bit;
        end
    end

    // Flags are qualified by out_valid and so hold with the result.
    always_comb begin
        out_zero = (r_state == DONE) && (r_data == '0);
        out_last = (r_state == DONE) && r_last;
    end
`else
    logic w_step_bit_unused;

    // The edge bit only feeds the optional flag.
    always_comb begin
        w_step_bit_unused = w_step_bit;
    end
`endif

    // Output decode from state and registered data.
    always_comb begin
        in_ready    = w_in_ready;
        out_valid   = (r_state == DONE);
        out_data    = r_data;
        busy        = (r_state == BUSY);
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_rot_shift_seq.sv
// tb_rot_shift_seq -- directed table-driven bench for rot_shift_seq (WIDTH=8).
module tb_rot_shift_seq;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [AMT_W-1:0] in_amt = '0;
    logic             in_dir = 1'b0;
    logic [1:0]       in_mode = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic [1:0]       dbg_state;
`ifdef ROT_SHIFT_SEQ_FLAGS_EN
    logic             out_zero;
    logic             out_last;
`endif

    int checks = 0;
    int errors = 0;

    rot_shift_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .in_dir     (in_dir),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
`ifdef ROT_SHIFT_SEQ_FLAGS_EN
        .out_zero   (out_zero),
        .out_last   (out_last),
`endif
        .o_dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    typedef struct {
        logic             dir;
        logic [1:0]       mode;
        logic [AMT_W-1:0] amt;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] exp;
        logic             exp_last;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a request at a negedge and hold it until it is accepted.
    task automatic send(input logic dir, input logic [1:0] mode,
                        input logic [AMT_W-1:0] amt, input logic [WIDTH-1:0] data);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_dir   = dir;
        in_mode  = mode;
        in_amt   = amt;
        in_data  = data;
        w = 0;
        #1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble the payload; the block must ignore it after accept.
        in_data  = WIDTH'($urandom_range(0, 255));
        in_amt   = AMT_W'($urandom_range(0, 7));
        in_dir   = ~dir;
        in_mode  = 2'($urandom_range(0, 3));
    endtask

    // Full operation with out_ready held high; checks result, latency, busy time.
    task automatic run_vec(input int idx);
        int lat;
        int busy_cnt;
        vec_t v;
        v = vecs[idx];
        out_ready = 1'b1;
        send(v.dir, v.mode, v.amt, v.data);
        lat = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 64) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d_latency", idx), lat, {29'd0, v.amt});
        check($sformatf("v%0d_busy_cycles", idx), busy_cnt, {29'd0, v.amt});
        check($sformatf("v%0d_data", idx), {24'd0, out_data}, {24'd0, v.exp});
`ifdef ROT_SHIFT_SEQ_FLAGS_EN
        check($sformatf("v%0d_zero", idx), {31'd0, out_zero}, {31'd0, (v.exp == '0)});
        check($sformatf("v%0d_last", idx), {31'd0, out_last}, {31'd0, v.exp_last});
`endif
        @(negedge clk);
        check($sformatf("v%0d_released", idx), {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        // dir, mode, amt, data, expected, expected edge bit
        vecs[0]  = '{1'b0, 2'b00, 3'd1, 8'h01, 8'h80, 1'b1}; // ror 1
        vecs[1]  = '{1'b1, 2'b00, 3'd3, 8'h96, 8'hB4, 1'b0}; // rol 3
        vecs[2]  = '{1'b0, 2'b10, 3'd2, 8'h90, 8'hE4, 1'b0}; // asr 2
        vecs[3]  = '{1'b0, 2'b01, 3'd2, 8'h90, 8'h24, 1'b0}; // lsr 2
        vecs[4]  = '{1'b1, 2'b01, 3'd7, 8'hFF, 8'h80, 1'b1}; // lsl 7
        vecs[5]  = '{1'b0, 2'b00, 3'd0, 8'h5A, 8'h5A, 1'b0}; // amt 0
        vecs[6]  = '{1'b0, 2'b01, 3'd3, 8'h05, 8'h00, 1'b1}; // lsr to zero
        vecs[7]  = '{1'b1, 2'b11, 3'd1, 8'h80, 8'h01, 1'b1}; // mode 11 = rol
        vecs[8]  = '{1'b1, 2'b10, 3'd1, 8'h81, 8'h02, 1'b1}; // asl = lsl
        vecs[9]  = '{1'b0, 2'b10, 3'd7, 8'h80, 8'hFF, 1'b0}; // asr 7
        vecs[10] = '{1'b0, 2'b00, 3'd7, 8'h01, 8'h02, 1'b0}; // ror 7
        vecs[11] = '{1'b1, 2'b01, 3'd4, 8'h3C, 8'hC0, 1'b1}; // lsl 4

        // Reset: in_ready must be low even with a pending request.
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ROT_SHIFT_SEQ_FLAGS_EN
        check("rst_out_last", {31'd0, out_last}, 32'd0);
`endif

        // Table-driven operations.
        for (int i = 0; i < 12; i++) begin
            run_vec(i);
        end

        // amt=0 under backpressure: result held, in_ready low until out_ready.
        out_ready = 1'b0;
        send(1'b0, 2'b00, 3'd0, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d_data", i), {24'd0, out_data}, 32'h5A);
            check($sformatf("bp%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("bp_done_valid", {31'd0, out_valid}, 32'd0);
        check("bp_done_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // Back-to-back: consume one result and load the next on the same edge.
        out_ready = 1'b0;
        send(1'b0, 2'b00, 3'd1, 8'h01);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first_data", {24'd0, out_data}, 32'h80);
        in_valid  = 1'b1;
        in_dir    = 1'b0;
        in_mode   = 2'b00;
        in_amt    = 3'd4;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b2b_busy%0d_state", k), {30'd0, dbg_state}, {30'd0, ST_BUSY});
            check($sformatf("b2b_busy%0d_valid", k), {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        check("b2b_second_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_second_data", {24'd0, out_data}, 32'h5A);
        @(negedge clk);

        // Reset in the middle of a long operation discards the request.
        out_ready = 1'b1;
        send(1'b0, 2'b00, 3'd7, 8'hFF);
        repeat (2) @(negedge clk);
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", {24'd0, out_data}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_result", seen, 32'd0);

        // A fresh request still works after the aborted one.
        run_vec(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
